fetch_decode_queue: RTL and testbench
=====================================

# fetch_decode_queue

Parametrised bundle queue between Fetch stage 2 and Decode, replacing the single-entry Fetch-to-Decode pipeline register. It buffers up to DEPTH fetch bundles of LANES instructions each. Each lane carries its own valid bit. The queue absorbs Decode stalls without stalling Fetch until it is full, and drops flushed work in one cycle. It also carries the branch-predictor update sideband as a one-cycle retimed bus that is cleared by reset only, never by flush or stall.

## Interface
- LANES, 4, instruction slots per bundle (≥1)
- DEPTH, 4, bundle entries (power of two, ≥2)
- PKT_W, 99, per-lane packet width: instruction + 2×PC + CTI index
- PC_W, 32, PC width
- BTYPE_W, 2, branch-type width
- BHR_W, 10, BHR snapshot width
- CNT_W, $clog2(DEPTH)+1, occupancy width (derived)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- flush_i  in  1  discard all queued bundles
- fs_valid_i  in  LANES  per-lane valid of the incoming bundle
- fs_pkt_i  in  LANES×PKT_W  incoming packets; lane 0 in the LSBs
- fs_ready_i  in  1  fs2Ready flag that travels with the bundle
- enq_ready_o  out  1  queue can accept a bundle
- dec_stall_i  in  1  Decode cannot take the head bundle
- dec_valid_o  out  LANES  per-lane valid of the head bundle
- dec_pkt_o  out  LANES×PKT_W  head packets
- dec_fs_ready_o  out  1  fs2Ready flag of the head bundle
- count_o  out  CNT_W  number of occupied entries
- upd_pc_i / upd_target_i  in  PC_W  predictor update PC / target
- upd_type_i  in  BTYPE_W  branch type
- upd_dir_i, upd_en_i  in  1  branch direction, update enable
- upd_bhr_i  in  BHR_W  BHR snapshot
- upd_pc_o, upd_target_o, upd_type_o, upd_dir_o, upd_en_o, upd_bhr_o  out  same widths  registered copies of the inputs

## Operation
- Enqueue when |fs_valid_i && enq_ready_o && !flush_i.
  - The entry stores fs_valid_i, fs_pkt_i and fs_ready_i, then wr_ptr++.
  - A bundle with all-zero fs_valid_i is never stored.
- enq_ready_o = (count < DEPTH). It is a pure function of state, with no combinational path from dec_stall_i.
- Fetch holds its bundle while enq_ready_o is low.
- Dequeue when count != 0 && !dec_stall_i && !flush_i; then rd_ptr++.
- Head outputs are taken from entry rd_ptr and gated by nonempty. When empty:
  - dec_valid_o = 0
  - dec_pkt_o = 0
  - dec_fs_ready_o = 0
- Occupancy count:
  - Enqueue + dequeue in the same cycle leaves count unchanged.
  - Enqueue only adds 1; dequeue only subtracts 1.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
- Flush has priority over enqueue and dequeue. On the next edge rd_ptr = wr_ptr = 0 and count = 0. Storage contents are left as is but become invisible.
- Sideband: every edge, upd_*_o <= upd_*_i, regardless of flush_i and dec_stall_i.
- Reset (asynchronous) sets:
  - pointers and count to 0, so enq_ready_o = 1
  - all dec_* outputs to 0
  - all upd_*_o to 0
  - Storage RAM is not reset.

## Timing
- Enqueue-to-head latency is 1 cycle. A bundle enqueued at edge t appears on dec_* after edge t.
- There is no same-cycle bypass when the queue is empty.
- Full (count = DEPTH): enq_ready_o = 0 even if a dequeue happens in that cycle. It returns to 1 the cycle after the dequeue.
- Flush asserted while full: enq_ready_o = 1 and count_o = 0 on the next cycle.
- Reset deasserted mid-stream: the first accepted bundle is the one presented at the first edge with reset low.
- Sideband latency is exactly 1 cycle.

## Structure
- The shared package fe_pkg holds:
  - PKT_W, PC_W, BTYPE_W, BHR_W
  - a packed bundle_t struct {valid[LANES], pkt[LANES], fs_ready}
- Sub-module fd_sideband_reg contains the async-reset, reset-only retiming of the upd_* bus.
- The queue pointer, count logic and storage live in the top module.

## Test plan
- **Reset:** assert reset mid-operation with count = 2. Required: count_o = 0, enq_ready_o = 1, dec_valid_o = 0, upd_en_o = 0 immediately (asynchronously).
- **Fill/drain:** DEPTH = 4, dec_stall_i = 1, push bundles A..E.
  - A–D are accepted; enq_ready_o goes low after D; count_o = 4.
  - Release the stall: A, B, C, D come out in order, one per cycle.
- **Simultaneous:** with count = 2, push and pop in the same cycle. Required: count_o stays 2 and the head advances to the next bundle.
- **Flush priority:** count = 3, flush_i = 1 with a valid push and dec_stall_i = 0. Next cycle: count_o = 0, dec_valid_o = 0, and the pushed bundle is absent.
- **Partial lanes:**
  - Push fs_valid_i = 4'b0101: the bundle appears with dec_valid_o = 4'b0101.
  - Push fs_valid_i = 0: count_o is unchanged.
- **Sideband:** hold dec_stall_i = 1 and flush_i = 1, drive upd_en_i = 1, upd_pc_i = 32'h0000_1000. Required: upd_en_o = 1 and upd_pc_o = 32'h1000 one cycle later.

Source files
------------

// File: rtl/fe_pkg.sv
// fe_pkg -- types and widths shared by the Fetch-to-Decode bundle queue.
//   LANES   : instruction slots per fetch bundle
//   PKT_W   : per-lane packet width (instruction + 2x PC + CTI index)
//   PC_W, BTYPE_W, BHR_W : branch-predictor update sideband widths
//   bundle_t: one queue entry {per-lane valid, per-lane packet, fs2Ready}
package fe_pkg;

  localparam int LANES   = 4;
  localparam int PKT_W   = 99;
  localparam int PC_W    = 32;
  localparam int BTYPE_W = 2;
  localparam int BHR_W   = 10;

  // Packed so that {valid, pkt, fs_ready} maps directly onto the port buses;
  // pkt lane 0 sits in the LSBs of the pkt field, matching fs_pkt_i.
  typedef struct packed {
    logic [LANES-1:0]            valid;
    logic [LANES-1:0][PKT_W-1:0] pkt;
    logic                        fs_ready;
  } bundle_t;

endpackage

// File: rtl/fd_sideband_reg.sv
// fd_sideband_reg -- one-cycle retiming of the branch-predictor update bus.
// The registers clear only on reset; flush and stall never touch them.
//   clk, reset          : clock, asynchronous active-high reset
//   upd_*_i             : update PC, target, type, direction, enable, BHR
//   upd_*_o             : the same fields, delayed by exactly one edge
module fd_sideband_reg
  import fe_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [PC_W-1:0]    upd_pc_i,
  input  logic [PC_W-1:0]    upd_target_i,
  input  logic [BTYPE_W-1:0] upd_type_i,
  input  logic               upd_dir_i,
  input  logic               upd_en_i,
  input  logic [BHR_W-1:0]   upd_bhr_i,
  output logic [PC_W-1:0]    upd_pc_o,
  output logic [PC_W-1:0]    upd_target_o,
  output logic [BTYPE_W-1:0] upd_type_o,
  output logic               upd_dir_o,
  output logic               upd_en_o,
  output logic [BHR_W-1:0]   upd_bhr_o
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upd_pc_o     <= '0;
      upd_target_o <= '0;
      upd_type_o   <= '0;
      upd_dir_o    <= 1'b0;
      upd_en_o     <= 1'b0;
      upd_bhr_o    <= '0;
    end else begin
      upd_pc_o     <= upd_pc_i;
      upd_target_o <= upd_target_i;
      upd_type_o   <= upd_type_i;
      upd_dir_o    <= upd_dir_i;
      upd_en_o     <= upd_en_i;
      upd_bhr_o    <= upd_bhr_i;
    end
  end

endmodule

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue -- DEPTH-entry bundle FIFO between Fetch stage 2 and
// Decode, plus the retimed branch-predictor update sideband.
//   clk, reset        : clock, asynchronous active-high reset
//   flush_i           : drop every queued bundle (wins over enq/deq)
//   fs_valid_i/pkt_i/ready_i, enq_ready_o : enqueue side
//   dec_stall_i, dec_valid_o/pkt_o/fs_ready_o : dequeue side (head entry)
//   count_o           : occupied entries
//   upd_*_i / upd_*_o : predictor update bus, one-cycle delayed
//
// Handshake: a bundle transfers into the queue on an edge where fs_valid_i
// has any lane set, enq_ready_o is high and flush_i is low; Fetch holds the
// bundle while enq_ready_o is low. The head transfers to Decode on an edge
// where the queue is non-empty, dec_stall_i is low and flush_i is low.
// enq_ready_o depends only on registered occupancy, never on dec_stall_i.
module fetch_decode_queue
  import fe_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush_i,
  input  logic [LANES-1:0]       fs_valid_i,
  input  logic [LANES*PKT_W-1:0] fs_pkt_i,
  input  logic                   fs_ready_i,
  output logic                   enq_ready_o,
  input  logic                   dec_stall_i,
  output logic [LANES-1:0]       dec_valid_o,
  output logic [LANES*PKT_W-1:0] dec_pkt_o,
  output logic                   dec_fs_ready_o,
  output logic [CNT_W-1:0]       count_o,
  input  logic [PC_W-1:0]        upd_pc_i,
  input  logic [PC_W-1:0]        upd_target_i,
  input  logic [BTYPE_W-1:0]     upd_type_i,
  input  logic                   upd_dir_i,
  input  logic                   upd_en_i,
  input  logic [BHR_W-1:0]       upd_bhr_i,
  output logic [PC_W-1:0]        upd_pc_o,
  output logic [PC_W-1:0]        upd_target_o,
  output logic [BTYPE_W-1:0]     upd_type_o,
  output logic                   upd_dir_o,
  output logic                   upd_en_o,
  output logic [BHR_W-1:0]       upd_bhr_o
);

  localparam int PTR_W = $clog2(DEPTH);

  bundle_t              mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 nonempty;
  logic                 do_enq;
  logic                 do_deq;
  bundle_t              wr_bundle;
  bundle_t              head;

  assign nonempty    = (count_q != '0);
  assign enq_ready_o = (count_q < CNT_W'(DEPTH));
  // All-zero valid bundles are bubbles and never occupy an entry.
  assign do_enq      = (|fs_valid_i) && enq_ready_o && !flush_i;
  assign do_deq      = nonempty && !dec_stall_i && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_enq, do_deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; stale entries are hidden by the occupancy gate.
  always_comb begin
    wr_bundle.valid    = fs_valid_i;
    wr_bundle.pkt      = fs_pkt_i;
    wr_bundle.fs_ready = fs_ready_i;
  end

  always_ff @(posedge clk) begin
    if (do_enq) mem_q[wr_ptr_q] <= wr_bundle;
  end

  // No bypass: an empty queue shows zeros even if Fetch is presenting a bundle.
  assign head           = mem_q[rd_ptr_q];
  assign dec_valid_o    = nonempty ? head.valid    : '0;
  assign dec_pkt_o      = nonempty ? head.pkt      : '0;
  assign dec_fs_ready_o = nonempty ? head.fs_ready : 1'b0;
  assign count_o        = count_q;

  fd_sideband_reg u_sideband (
    .clk          (clk),
    .reset        (reset),
    .upd_pc_i     (upd_pc_i),
    .upd_target_i (upd_target_i),
    .upd_type_i   (upd_type_i),
    .upd_dir_i    (upd_dir_i),
    .upd_en_i     (upd_en_i),
    .upd_bhr_i    (upd_bhr_i),
    .upd_pc_o     (upd_pc_o),
    .upd_target_o (upd_target_o),
    .upd_type_o   (upd_type_o),
    .upd_dir_o    (upd_dir_o),
    .upd_en_o     (upd_en_o),
    .upd_bhr_o    (upd_bhr_o)
  );

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue: a driver issues bundles and pushes
// the bundles it expects Decode to receive into exp_q; a negedge monitor pops
// and compares every head bundle that Decode actually takes.
module tb_fetch_decode_queue;
  import fe_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int BW    = LANES + LANES*PKT_W + 1;

  logic                   clk;
  logic                   reset;
  logic                   flush_i;
  logic [LANES-1:0]       fs_valid_i;
  logic [LANES*PKT_W-1:0] fs_pkt_i;
  logic                   fs_ready_i;
  logic                   enq_ready_o;
  logic                   dec_stall_i;
  logic [LANES-1:0]       dec_valid_o;
  logic [LANES*PKT_W-1:0] dec_pkt_o;
  logic                   dec_fs_ready_o;
  logic [CNT_W-1:0]       count_o;
  logic [PC_W-1:0]        upd_pc_i, upd_target_i, upd_pc_o, upd_target_o;
  logic [BTYPE_W-1:0]     upd_type_i, upd_type_o;
  logic                   upd_dir_i, upd_en_i, upd_dir_o, upd_en_o;
  logic [BHR_W-1:0]       upd_bhr_i, upd_bhr_o;

  logic [BW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  fetch_decode_queue #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .flush_i        (flush_i),
    .fs_valid_i     (fs_valid_i),
    .fs_pkt_i       (fs_pkt_i),
    .fs_ready_i     (fs_ready_i),
    .enq_ready_o    (enq_ready_o),
    .dec_stall_i    (dec_stall_i),
    .dec_valid_o    (dec_valid_o),
    .dec_pkt_o      (dec_pkt_o),
    .dec_fs_ready_o (dec_fs_ready_o),
    .count_o        (count_o),
    .upd_pc_i       (upd_pc_i),
    .upd_target_i   (upd_target_i),
    .upd_type_i     (upd_type_i),
    .upd_dir_i      (upd_dir_i),
    .upd_en_i       (upd_en_i),
    .upd_bhr_i      (upd_bhr_i),
    .upd_pc_o       (upd_pc_o),
    .upd_target_o   (upd_target_o),
    .upd_type_o     (upd_type_o),
    .upd_dir_o      (upd_dir_o),
    .upd_en_o       (upd_en_o),
    .upd_bhr_o      (upd_bhr_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, act=running req=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [LANES*PKT_W-1:0] mk_pkt(input int id);
    logic [LANES*PKT_W-1:0] r;
    for (int l = 0; l < LANES; l++)
      r[l*PKT_W +: PKT_W] = {35'h5A5, id[31:0], l[31:0]};
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: act=%0h req=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a bundle; acc says whether Decode should eventually receive it.
  task automatic drive(input logic [LANES-1:0] v, input int id, input bit acc);
    logic [LANES*PKT_W-1:0] p;
    p          = mk_pkt(id);
    fs_valid_i = v;
    fs_pkt_i   = p;
    fs_ready_i = id[0];
    if (acc) exp_q.push_back({v, p, id[0]});
  endtask

  task automatic idle_fetch();
    fs_valid_i = '0;
    fs_pkt_i   = '0;
    fs_ready_i = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [BW-1:0] act, req;
    if (!reset && dec_valid_o != '0 && !dec_stall_i && !flush_i) begin
      act = {dec_valid_o, dec_pkt_o, dec_fs_ready_o};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL head_unexpected: act=%0h req=none", act);
      end else begin
        req = exp_q.pop_front();
        if (act !== req) begin
          n_fail++;
          $display("FAIL head_bundle: act=%0h req=%0h", act, req);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [LANES*PKT_W-1:0] p;
    reset = 1'b0; flush_i = 1'b0; dec_stall_i = 1'b0;
    idle_fetch();
    upd_pc_i = '0; upd_target_i = '0; upd_type_i = '0;
    upd_dir_i = 1'b0; upd_en_i = 1'b0; upd_bhr_i = '0;
    #1 reset = 1'b1;
    step();
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_enq_ready", 64'(enq_ready_o), 64'd1);
    check("rst_dec_valid", 64'(dec_valid_o), 64'd0);
    check("rst_upd_en", 64'(upd_en_o), 64'd0);
    step();
    reset = 1'b0;

    // Fill A..E under stall: only A..D fit.
    dec_stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(4'hF, 10 + i, i < 4);
      check("fill_enq_ready", 64'(enq_ready_o), (i < 4) ? 64'd1 : 64'd0);
      step();
    end
    idle_fetch();
    check("full_count", 64'(count_o), 64'd4);
    check("full_enq_ready", 64'(enq_ready_o), 64'd0);
    dec_stall_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("drain_count", 64'(count_o), 64'(3 - i));
    end
    check("drain_enq_ready", 64'(enq_ready_o), 64'd1);
    check("empty_fs_ready", 64'(dec_fs_ready_o), 64'd0);

    // Simultaneous push and pop at count 2.
    dec_stall_i = 1'b1;
    drive(4'hF, 20, 1'b1); step();
    drive(4'hF, 21, 1'b1); step();
    drive(4'hF, 22, 1'b1); dec_stall_i = 1'b0;
    step();
    idle_fetch(); dec_stall_i = 1'b1;
    check("simul_count", 64'(count_o), 64'd2);
    p = mk_pkt(21);
    check("simul_head", dec_pkt_o[63:0], p[63:0]);

    // Flush priority at count 3 with a push and no stall.
    drive(4'hF, 23, 1'b1); step();
    check("pre_flush_count", 64'(count_o), 64'd3);
    flush_i = 1'b1; dec_stall_i = 1'b0;
    drive(4'hF, 24, 1'b0);
    exp_q.delete();
    step();
    flush_i = 1'b0; idle_fetch();
    check("flush_count", 64'(count_o), 64'd0);
    check("flush_dec_valid", 64'(dec_valid_o), 64'd0);
    check("flush_enq_ready", 64'(enq_ready_o), 64'd1);

    // Partial lanes and an all-zero bundle.
    dec_stall_i = 1'b1;
    drive(4'b0101, 30, 1'b1); step();
    check("partial_count", 64'(count_o), 64'd1);
    check("partial_valid", 64'(dec_valid_o), 64'h5);
    drive(4'b0000, 31, 1'b0); step();
    check("zero_valid_count", 64'(count_o), 64'd1);
    idle_fetch(); dec_stall_i = 1'b0;
    step();
    check("partial_drained", 64'(count_o), 64'd0);

    // Sideband passes through stall and flush with one cycle of latency.
    dec_stall_i = 1'b1; flush_i = 1'b1;
    upd_en_i = 1'b1; upd_pc_i = 32'h0000_1000; upd_target_i = 32'h0000_2040;
    upd_type_i = 2'd2; upd_dir_i = 1'b1; upd_bhr_i = 10'h3A5;
    check("sb_before_edge", 64'(upd_en_o), 64'd0);
    step();
    check("sb_en", 64'(upd_en_o), 64'd1);
    check("sb_pc", 64'(upd_pc_o), 64'h1000);
    check("sb_target", 64'(upd_target_o), 64'h2040);
    check("sb_type_dir_bhr", 64'({upd_type_o, upd_dir_o, upd_bhr_o}), 64'({2'd2, 1'b1, 10'h3A5}));
    flush_i = 1'b0;

    // Asynchronous reset with two entries queued.
    drive(4'hF, 40, 1'b1); step();
    drive(4'hF, 41, 1'b1); step();
    idle_fetch();
    check("pre_reset_count", 64'(count_o), 64'd2);
    #2 reset = 1'b1;
    #1;
    exp_q.delete();
    check("async_rst_count", 64'(count_o), 64'd0);
    check("async_rst_enq_ready", 64'(enq_ready_o), 64'd1);
    check("async_rst_dec_valid", 64'(dec_valid_o), 64'd0);
    check("async_rst_upd_en", 64'(upd_en_o), 64'd0);
    step();
    // First bundle presented with reset low is the first one accepted.
    reset = 1'b0; dec_stall_i = 1'b0;
    drive(4'b1010, 50, 1'b1);
    step();
    idle_fetch();
    check("post_reset_count", 64'(count_o), 64'd1);
    step(); step();
    check("final_count", 64'(count_o), 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
